// File: rtl/demux_if.sv
// Control pins of the external latched-address analog multiplexer.
interface demux_if;
  logic [4:0] set_ch;
  logic       ena;
  logic       cs;
  logic       wr;

  modport master (output set_ch, ena, cs, wr);
  modport slave  (input  set_ch, ena, cs, wr);
endinterface

// File: rtl/demux.sv
// Channel sequencer for a 32:1 latched-address analog mux: prescaled stepping plus CS/WR strobes.
// Optional DEMUX_HOLD_EN adds a `hold` input that suspends tick-driven stepping.
module demux #(
  parameter logic [23:0] CLK_DIVIDER = 24'd1200000,
  parameter int          NUM_CH      = 32,
  parameter int          WR_PULSE    = 2
) (
  input  logic     clk,
  input  logic     rst,
`ifdef DEMUX_HOLD_EN
  input  logic     hold,
`endif
  demux_if.master  mux
);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;

  // 0 and 1 collapse to a terminal count of 0, giving a tick every cycle
  localparam logic [23:0] DIV_LAST = (CLK_DIVIDER <= 24'd1) ? 24'd0 : CLK_DIVIDER - 24'd1;
  localparam logic [4:0]  CH_LAST  = 5'(NUM_CH - 1);
  localparam logic [3:0]  WR_LAST  = 4'(WR_PULSE - 1);

  logic [23:0] r_div_cnt;
  logic [3:0]  r_wcnt;
  logic [4:0]  r_set_ch;
  logic        r_cs, r_wr, r_ena;
  logic        r_pending, r_first;
  state_t      r_state, w_state_nxt;
  logic        w_tick, w_hold, w_go;
  logic        w_cs_nxt, w_wr_nxt;

`ifdef DEMUX_HOLD_EN
  assign w_hold = hold;
`else
  assign w_hold = 1'b0;
`endif

  assign w_tick = (r_div_cnt == DIV_LAST);
  // the initial write ignores hold; later steps need a tick or a queued one
  assign w_go   = r_first | (~w_hold & (w_tick | r_pending));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_div_cnt <= '0;
    else      r_div_cnt <= w_tick ? '0 : r_div_cnt + 24'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = WRITE;
      WRITE:   if (r_wcnt == WR_LAST) w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // outputs decoded from the next state and then registered, so pins track the state
  always_comb begin
    w_cs_nxt = 1'b1;
    w_wr_nxt = 1'b1;
    case (w_state_nxt)
      SETUP:   w_cs_nxt = 1'b0;
      WRITE:   begin w_cs_nxt = 1'b0; w_wr_nxt = 1'b0; end
      HOLD:    w_cs_nxt = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cs <= 1'b1;
      r_wr <= 1'b1;
    end else begin
      r_cs <= w_cs_nxt;
      r_wr <= w_wr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_wcnt <= '0;
    else      r_wcnt <= (r_state == WRITE) ? r_wcnt + 4'd1 : 4'd0;
  end

  // ticks landing while busy collapse into a single queued step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   r_pending <= 1'b0;
    else if (r_state != IDLE) begin
      if (w_tick && !w_hold)    r_pending <= 1'b1;
    end else if (w_go)          r_pending <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_set_ch <= '0;
    else if (r_state == IDLE && w_go)
      r_set_ch <= (r_first || r_set_ch == CH_LAST) ? 5'd0 : r_set_ch + 5'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_first <= 1'b1;
      r_ena   <= 1'b0;
    end else if (r_state == HOLD && r_first) begin
      r_first <= 1'b0;
      r_ena   <= 1'b1;
    end
  end

  assign mux.set_ch = r_set_ch;
  assign mux.cs     = r_cs;
  assign mux.wr     = r_wr;
  assign mux.ena    = r_ena;

endmodule

// File: tb/tb_demux.sv
// Four demux configurations share clock and reset; each is compared every cycle
// against a sequence-level model built from start-edge arithmetic.
`timescale 1ns/1ps
module tb_demux;
  localparam real HALF = 41.667;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(HALF) clk = ~clk;

`ifdef DEMUX_HOLD_EN
  logic hold = 1'b0;
`endif

  demux_if if0 ();
  demux_if if1 ();
  demux_if if2 ();
  demux_if if3 ();

  demux #(.CLK_DIVIDER(24'd100), .NUM_CH(32), .WR_PULSE(2)) u0 (
    .clk(clk), .rst(rst),
`ifdef DEMUX_HOLD_EN
    .hold(hold),
`endif
    .mux(if0));
  demux #(.CLK_DIVIDER(24'd10), .NUM_CH(4), .WR_PULSE(2)) u1 (
    .clk(clk), .rst(rst),
`ifdef DEMUX_HOLD_EN
    .hold(hold),
`endif
    .mux(if1));
  demux #(.CLK_DIVIDER(24'd1), .NUM_CH(32), .WR_PULSE(2)) u2 (
    .clk(clk), .rst(rst),
`ifdef DEMUX_HOLD_EN
    .hold(hold),
`endif
    .mux(if2));
  demux #(.CLK_DIVIDER(24'd0), .NUM_CH(5), .WR_PULSE(1)) u3 (
    .clk(clk), .rst(rst),
`ifdef DEMUX_HOLD_EN
    .hold(hold),
`endif
    .mux(if3));

  int cd  [4] = '{100, 10, 1, 0};
  int cn  [4] = '{32, 4, 32, 5};
  int cw  [4] = '{2, 2, 2, 1};

  logic [7:0] obs [4];
  assign obs[0] = {if0.set_ch, if0.cs, if0.wr, if0.ena};
  assign obs[1] = {if1.set_ch, if1.cs, if1.wr, if1.ena};
  assign obs[2] = {if2.set_ch, if2.cs, if2.wr, if2.ena};
  assign obs[3] = {if3.set_ch, if3.cs, if3.wr, if3.ena};

  int n_vec = 0;
  int n_err = 0;

  // Expected {set_ch, cs, wr, ena} after n rising edges since reset release.
  // Sequence k enters SETUP at edge s_k; s_0 = 1. A tick on a busy edge
  // (s+1 .. s+wr+2) queues the next start at s+wr+3, else it starts at the tick.
  function automatic logic [7:0] model(input int d, input int wr, input int nch, input int n);
    int p, s, k, t, nx;
    logic [4:0] ch;
    logic cs, ws, en;
    if (n == 0) return {5'd0, 3'b110};
    p = (d <= 1) ? 1 : d;
    s = 1;
    k = 0;
    while (1) begin
      t  = (s / p + 1) * p;
      nx = (t <= s + wr + 2) ? s + wr + 3 : t;
      if (nx > n) break;
      s = nx;
      k++;
    end
    ch = 5'(k % nch);
    cs = !(n >= s && n <= s + wr + 1);
    ws = !(n >= s + 1 && n <= s + wr);
    en = (n >= wr + 3);
    return {ch, cs, ws, en};
  endfunction

  task automatic chk(input string tag, input int idx, input int n, input logic [7:0] exp);
    n_vec++;
    assert (obs[idx] === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d n=%0d got ch=%0d cs/wr/ena=%b exp ch=%0d cs/wr/ena=%b",
             tag, idx, n, obs[idx][7:3], obs[idx][2:0], exp[7:3], exp[2:0]);
    end
  endtask

  task automatic run_round(input int len);
    @(negedge clk);
    #($urandom_range(5, 30));
    rst = 1'b1;
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk("seq", i, n, model(cd[i], cw[i], cn[i], n));
    end
    // asynchronous reset mid-cycle, checked before the next clock edge
    @(negedge clk);
    #($urandom_range(5, 30));
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk("async_rst", i, len, {5'd0, 3'b110});
  endtask

  initial begin
    #10 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk("reset", i, 0, {5'd0, 3'b110});
    run_round(3);
    run_round(520);
    run_round($urandom_range(20, 300));
    run_round($urandom_range(20, 300));
    run_round($urandom_range(20, 300));
    run_round(60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux.md
Name: demux

Overview:
- Channel sequencer for an external 32:1 analog multiplexer with a latched address (CS/WR/EN style interface).
- A prescaler divides the system clock by CLK_DIVIDER. On every prescaler tick the block advances the channel address `set_ch` and issues a chip-select/write strobe sequence so the external mux latches the new address.
- Sits between the board clock (12 MHz) and the mux control pins.

Parameters:
- CLK_DIVIDER, 24'd1200000, clock cycles per channel step; values 0 and 1 both mean a step request every cycle.
- NUM_CH, 32, number of channels scanned (1..32); set_ch wraps at NUM_CH-1.
- WR_PULSE, 2, width of the wr low pulse in clock cycles (1..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- set_ch  out  5  current channel address driven to the mux.
- ena  out  1  mux output enable, active-high.
- cs  out  1  mux chip select, active-low.
- wr  out  1  mux address write strobe, active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - div_cnt=0, set_ch=0, cs=1, wr=1, ena=0.
  - FSM=IDLE, pending=0, first=1.
- Prescaler:
  - div_cnt counts 0..CLK_DIVIDER-1, then wraps to 0.
  - tick=1 for one cycle when div_cnt==CLK_DIVIDER-1 (every cycle if CLK_DIVIDER<=1).
  - The first tick occurs CLK_DIVIDER cycles after reset release.
  - The prescaler free-runs regardless of FSM state.
- Initial write: on the first clock after reset release, the FSM starts a write sequence for channel 0 without waiting for a tick. first clears when that sequence ends.
- Write sequence FSM: IDLE -> SETUP -> WRITE -> HOLD -> IDLE.
  - IDLE: cs=1, wr=1. Leaves when a tick occurs, pending=1, or first=1.
  - SETUP (1 cycle): cs=0, wr=1.
    - set_ch is updated on entry to SETUP: +1 if not the initial write; NUM_CH-1 wraps to 0.
    - set_ch holds its value from SETUP through the next SETUP.
  - WRITE (WR_PULSE cycles): cs=0, wr=0.
  - HOLD (1 cycle): cs=0, wr=1. The mux latches on the wr rising edge.
  - Return to IDLE: cs=1.
- ena: 0 from reset until the end of the initial write sequence, then 1 permanently until the next reset.
- Tick while FSM is not IDLE: sets pending. The next sequence starts on the IDLE cycle, and pending clears there.
  - Multiple ticks while busy collapse into one pending step; a channel is never skipped by more than 1 per sequence.
- Sequence length: WR_PULSE+3 cycles including IDLE. For CLK_DIVIDER >= WR_PULSE+3, every tick produces exactly one step with no pending use.
- Reset mid-sequence: all outputs return to reset values immediately, asynchronously.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: DEMUX_HOLD_EN.
- When defined, the block gains an input port `hold` (1 bit, active-high).
  - While hold=1, ticks are ignored and do not set pending; set_ch, cs and wr stay frozen in IDLE values.
  - A sequence already in progress completes normally.
  - The prescaler keeps running.
  - The initial write is not blocked by hold.
- When not defined, the port does not exist and stepping is unconditional.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle -> set_ch=0, cs=1, wr=1, ena=0 within the same time step. Repeat with rst asserted during WRITE.
- Initial write: CLK_DIVIDER=100, WR_PULSE=2, release rst -> set_ch stays 0; cs low for 4 cycles; wr low for exactly 2 cycles inside the cs window; ena=1 after HOLD.
- Stepping: CLK_DIVIDER=100, 12 MHz clock, run 40 us -> set_ch steps 0,1,2,3,4 at 100-cycle intervals, with one cs/wr sequence per step and no extra strobes.
- Wrap: NUM_CH=4, CLK_DIVIDER=10 -> set_ch sequence 0,1,2,3,0,1. wr low only while cs low; set_ch stable while cs=0.
- Overrun: CLK_DIVIDER=1, WR_PULSE=2 -> back-to-back sequences, set_ch increments by exactly 1 per sequence, and cs returns high for exactly 1 cycle between sequences.
- DEMUX_HOLD_EN: assert hold for 300 cycles with CLK_DIVIDER=100 -> no cs/wr activity and set_ch unchanged; after deassertion, stepping resumes at the next tick.
